shift_reg_deser: RTL and testbench
==================================

// Module: shift_reg_deser
// PURPOSE
//   Parametrised serial-to-parallel deserialiser; successor to the 1-bit SIPO shift register.
//   Accepts a lane of `lane` bits per valid cycle and assembles `size` lanes into one word.
//   Supports MSB-first or LSB-first ordering and posts each word into a holding register
//   with a valid/ready handshake. Sits between serial front-ends and word-wide consumers.
// PARAMETERS
//   size   8   lanes per word (>=2); counter width is $clog2(size)
//   lane   1   bits shifted in per accepted cycle (>=1); word width W = size*lane
// PORTS
//   clk        in   1        single clock, all state updates on posedge
//   reset      in   1        synchronous, active-high
//   datain     in   lane     serial lane data
//   din_valid  in   1        datain is valid this cycle; input is always accepted (no backpressure)
//   msb_first  in   1        1 = first lane lands in the MSBs; 0 = first lane lands in the LSBs
//   dataout    out  W        holding-register word
//   dout_valid out  1        dataout holds an unconsumed word
//   dout_ready in   1        consumer takes the word on an edge where dout_valid && dout_ready
//   overrun    out  1        one-cycle pulse: a completed word was dropped
//   count      out  $clog2(size)  lanes collected in the current partial word
// BEHAVIOUR
//   Reset: shift reg=0, count=0, dataout=0, dout_valid=0, overrun=0, latched mode=1 (MSB-first).
//   Accept: on an edge with din_valid=1, datain is shifted in and count is incremented.
//     din_valid=0 holds the shift register and count unchanged, so gaps of any length are allowed.
//   Mode: msb_first is sampled and latched on the accepting edge where count==0.
//     Changes in the middle of a word are ignored until the next word starts.
//   MSB-first: sr <= {sr[W-lane-1:0], datain}.
//   LSB-first: sr <= {datain, sr[W-1:lane]}.
//   Completion: the accepting edge with count==size-1 is the completing edge. On that edge:
//     - the assembled word, including this lane, is formed;
//     - count wraps to 0 and the shift register restarts cleanly.
//   Latency: the word appears on dataout, with dout_valid=1, in the cycle after the completing edge.
//   Output FSM (EMPTY/FULL):
//     EMPTY + completion                         -> FULL, load word
//     FULL + dout_ready, no completion           -> EMPTY
//     FULL + dout_ready + completion (same edge) -> stay FULL, load new word, no bubble
//     FULL + !dout_ready + completion            -> stay FULL, keep old word, overrun=1 for 1 cycle
//   dataout is stable while in FULL; it is never modified except by a load.
//   Reset mid-word or mid-handshake discards everything and returns to the reset values.
// CONFIGURATION
//   SHIFT_REG_DESER_PARITY_EN defined:
//     - adds output dout_parity (1 bit) = ^dataout (even parity);
//     - registered alongside dataout, same load rules, reset value 0.
//   Undefined: port absent; no parity logic.
// STRUCTURE
//   Package shift_reg_pkg:
//     - typedef enum {OUT_EMPTY, OUT_FULL} out_state_t;
//     - localparam MODE_LSB_FIRST=0 and MODE_MSB_FIRST=1.
//   Sub-module shift_reg_lane_ctr: modulo-`size` counter with enable; outputs count and a wrap
//     strobe (the completing edge).
//   Top-level: shift datapath, mode latch, output FSM, overrun pulse.
// TESTING (size=8, lane=1 unless stated)
//   1. MSB-first: 1,0,1,1,0,0,1,1 on 8 consecutive valid cycles, dout_ready=1
//      -> dataout=8'hB3, dout_valid for 1 cycle.
//   2. LSB-first: same bit stream -> dataout=8'hCD. msb_first toggled at bit 4 has no effect.
//   3. din_valid=0 gaps of 3 cycles between bits -> same 8'hB3 result; count holds during gaps.
//   4. dout_ready=0 with two words 8'hB3 then 8'h5A -> dataout stays 8'hB3 and overrun pulses once;
//      raising dout_ready then drops dout_valid.
//   5. Back-to-back 8'hB3, 8'h5A with dout_ready=1 on the completion edge of the second word
//      -> dout_valid stays high and dataout changes 8'hB3 -> 8'h5A.
//   6. reset asserted after 5 bits -> count=0, dout_valid=0. Next 8 bits give a clean word.
//      Plus: lane=4, size=4, MSB-first nibbles A,B,C,D -> 16'hABCD.
//      Plus: with SHIFT_REG_DESER_PARITY_EN, 8'hB3 -> dout_parity=1.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the shift_reg_deser deserialiser.
package shift_reg_pkg;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    localparam logic MODE_LSB_FIRST = 1'b0;
    localparam logic MODE_MSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_reg_lane_ctr.sv
// Modulo-size lane counter with enable; wrap marks the accepting edge that completes a word.
module shift_reg_lane_ctr #(
    parameter int size = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    output logic [$clog2(size)-1:0]  count,
    output logic                     wrap
);
    localparam int CW = $clog2(size);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        wrap    = en && (count_q == CW'(size - 1));
        count_d = count_q;
        if (wrap)
            count_d = '0;
        else if (en)
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/shift_reg_deser.sv
// Serial-to-parallel deserialiser: size lanes of lane bits into one word, valid/ready holding register.
// Optional even-parity output dout_parity when SHIFT_REG_DESER_PARITY_EN is defined.
module shift_reg_deser
    import shift_reg_pkg::*;
#(
    parameter int size = 8,
    parameter int lane = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [lane-1:0]          datain,
    input  logic                     din_valid,
    input  logic                     msb_first,
    output logic [size*lane-1:0]     dataout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     overrun,
    output logic [$clog2(size)-1:0]  count
`ifdef SHIFT_REG_DESER_PARITY_EN
    ,
    output logic                     dout_parity
`endif
);
    localparam int W = size * lane;

    logic         wrap;
    logic         mode_q, mode_d;
    logic         eff_msb;
    logic [W-1:0] sr_q, sr_d;
    logic [W-1:0] shifted;
    logic [W-1:0] dout_q, dout_d;
    logic         ovr_q, ovr_d;
    logic         load;
    out_state_t   state_q, state_d;

    shift_reg_lane_ctr #(.size(size)) u_ctr (
        .clk   (clk),
        .reset (reset),
        .en    (din_valid),
        .count (count),
        .wrap  (wrap)
    );

    // The first lane of a word uses msb_first directly; later lanes use the latched mode.
    always_comb begin
        eff_msb = (count == '0) ? msb_first : mode_q;
        mode_d  = mode_q;
        if (din_valid && count == '0)
            mode_d = msb_first;

        if (eff_msb == MODE_MSB_FIRST)
            shifted = {sr_q[W-lane-1:0], datain};
        else
            shifted = {datain, sr_q[W-1:lane]};

        sr_d = sr_q;
        if (din_valid)
            sr_d = wrap ? '0 : shifted;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        ovr_d   = 1'b0;
        case (state_q)
            OUT_EMPTY: begin
                if (wrap) begin
                    state_d = OUT_FULL;
                    load    = 1'b1;
                end
            end
            OUT_FULL: begin
                if (wrap && dout_ready)
                    load = 1'b1;
                else if (wrap)
                    ovr_d = 1'b1;
                else if (dout_ready)
                    state_d = OUT_EMPTY;
            end
            default: state_d = OUT_EMPTY;
        endcase
        dout_d = load ? shifted : dout_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q  <= MODE_MSB_FIRST;
            sr_q    <= '0;
            dout_q  <= '0;
            ovr_q   <= 1'b0;
            state_q <= OUT_EMPTY;
        end else begin
            mode_q  <= mode_d;
            sr_q    <= sr_d;
            dout_q  <= dout_d;
            ovr_q   <= ovr_d;
            state_q <= state_d;
        end
    end

    assign dataout    = dout_q;
    assign dout_valid = (state_q == OUT_FULL);
    assign overrun    = ovr_q;

`ifdef SHIFT_REG_DESER_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = load ? ^shifted : par_q;
    end

    always_ff @(posedge clk) begin
        if (reset)
            par_q <= 1'b0;
        else
            par_q <= par_d;
    end

    assign dout_parity = par_q;
`endif

endmodule

// File: tb/tb_shift_reg_deser.sv
// Directed self-checking bench for shift_reg_deser (size=8/lane=1 and size=4/lane=4 instances).
module tb_shift_reg_deser;

    logic       clk = 1'b0;
    logic       reset;
    logic       datain, din_valid, msb_first, dout_ready;
    logic [7:0] dataout;
    logic       dout_valid, overrun;
    logic [2:0] count;

    logic [3:0]  datain4;
    logic        din_valid4, msb_first4, dout_ready4;
    logic [15:0] dataout4;
    logic        dout_valid4, overrun4;
    logic [1:0]  count4;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef SHIFT_REG_DESER_PARITY_EN
    logic dout_parity, dout_parity4;
`endif

    always #5 clk = ~clk;

    shift_reg_deser #(.size(8), .lane(1)) dut (
        .clk(clk), .reset(reset), .datain(datain), .din_valid(din_valid),
        .msb_first(msb_first), .dataout(dataout), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .overrun(overrun), .count(count)
`ifdef SHIFT_REG_DESER_PARITY_EN
        , .dout_parity(dout_parity)
`endif
    );

    shift_reg_deser #(.size(4), .lane(4)) dut4 (
        .clk(clk), .reset(reset), .datain(datain4), .din_valid(din_valid4),
        .msb_first(msb_first4), .dataout(dataout4), .dout_valid(dout_valid4),
        .dout_ready(dout_ready4), .overrun(overrun4), .count(count4)
`ifdef SHIFT_REG_DESER_PARITY_EN
        , .dout_parity(dout_parity4)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        datain    = b;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Stream order is s[7] first down to s[0].
    task automatic send_stream(input logic [7:0] s);
        for (int i = 7; i >= 0; i--) send_bit(s[i]);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", dout_valid); end
        n_checks++; if (dataout !== 8'h00) begin n_fail++; $display("FAIL reset_dataout got %h exp 00", dataout); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %b exp 0", overrun); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_msb();
        msb_first = 1'b1; dout_ready = 1'b1;
        send_stream(8'hB3);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL msb_valid got %b exp 1", dout_valid); end
        n_checks++; if (dataout !== 8'hB3) begin n_fail++; $display("FAIL msb_data got %h exp b3", dataout); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL msb_count_wrap got %0d exp 0", count); end
`ifdef SHIFT_REG_DESER_PARITY_EN
        n_checks++; if (dout_parity !== 1'b1) begin n_fail++; $display("FAIL msb_parity got %b exp 1", dout_parity); end
`endif
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL msb_valid_drop got %b exp 0", dout_valid); end
        n_checks++; if (dataout !== 8'hB3) begin n_fail++; $display("FAIL msb_data_hold got %h exp b3", dataout); end
    endtask

    task automatic test_lsb();
        logic [7:0] s;
        s = 8'hB3;
        msb_first = 1'b0; dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i == 3) msb_first = 1'b1;
            send_bit(s[i]);
        end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL lsb_valid got %b exp 1", dout_valid); end
        n_checks++; if (dataout !== 8'hCD) begin n_fail++; $display("FAIL lsb_data got %h exp cd", dataout); end
        tick();
        msb_first = 1'b1;
    endtask

    task automatic test_gaps();
        logic [7:0] s;
        s = 8'hB3;
        msb_first = 1'b1; dout_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(s[i]);
            if (i > 0) repeat (3) tick();
            if (i == 5) begin
                n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL gap_count_hold got %0d exp 3", count); end
            end
        end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL gap_valid got %b exp 1", dout_valid); end
        n_checks++; if (dataout !== 8'hB3) begin n_fail++; $display("FAIL gap_data got %h exp b3", dataout); end
        tick();
    endtask

    task automatic test_overrun();
        msb_first = 1'b1; dout_ready = 1'b0;
        send_stream(8'hB3);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_first got %b exp 0", overrun); end
        send_stream(8'h5A);
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_pulse got %b exp 1", overrun); end
        n_checks++; if (dataout !== 8'hB3) begin n_fail++; $display("FAIL ovr_keep got %h exp b3", dataout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL ovr_valid got %b exp 1", dout_valid); end
        tick();
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_one_cycle got %b exp 0", overrun); end
        dout_ready = 1'b1;
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drain got %b exp 0", dout_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] s;
        s = 8'h5A;
        msb_first = 1'b1; dout_ready = 1'b0;
        send_stream(8'hB3);
        for (int i = 7; i >= 1; i--) send_bit(s[i]);
        n_checks++; if (dataout !== 8'hB3) begin n_fail++; $display("FAIL b2b_first got %h exp b3", dataout); end
        dout_ready = 1'b1;
        send_bit(s[0]);
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid got %b exp 1", dout_valid); end
        n_checks++; if (dataout !== 8'h5A) begin n_fail++; $display("FAIL b2b_data got %h exp 5a", dataout); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL b2b_overrun got %b exp 0", overrun); end
`ifdef SHIFT_REG_DESER_PARITY_EN
        n_checks++; if (dout_parity !== 1'b0) begin n_fail++; $display("FAIL b2b_parity got %b exp 0", dout_parity); end
`endif
        tick();
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", dout_valid); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] s;
        s = 8'hFF;
        msb_first = 1'b1; dout_ready = 1'b0;
        send_stream(8'hB3);
        for (int i = 0; i < 5; i++) send_bit(s[i]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rmid_count got %0d exp 0", count); end
        n_checks++; if (dout_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", dout_valid); end
        n_checks++; if (dataout !== 8'h00) begin n_fail++; $display("FAIL rmid_data got %h exp 00", dataout); end
        dout_ready = 1'b1;
        send_stream(8'h5A);
        n_checks++; if (dataout !== 8'h5A) begin n_fail++; $display("FAIL rmid_clean got %h exp 5a", dataout); end
        n_checks++; if (dout_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_clean_valid got %b exp 1", dout_valid); end
        tick();
    endtask

    task automatic test_wide();
        logic [15:0] s;
        s = 16'hABCD;
        msb_first4 = 1'b1; dout_ready4 = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            datain4    = s[i*4 +: 4];
            din_valid4 = 1'b1;
            tick();
            din_valid4 = 1'b0;
        end
        n_checks++; if (dout_valid4 !== 1'b1) begin n_fail++; $display("FAIL wide_valid got %b exp 1", dout_valid4); end
        n_checks++; if (dataout4 !== 16'hABCD) begin n_fail++; $display("FAIL wide_data got %h exp abcd", dataout4); end
        tick();
    endtask

    initial begin
        reset = 1'b1; datain = 1'b0; din_valid = 1'b0; msb_first = 1'b1; dout_ready = 1'b0;
        datain4 = 4'h0; din_valid4 = 1'b0; msb_first4 = 1'b1; dout_ready4 = 1'b0;
        test_reset();
        test_msb();
        test_lsb();
        test_gaps();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
